// File: rtl/dtree_seq_ctrl.sv
// Loads one frame of NUM_FEAT features for an external combinational tree and captures its class once settled.
// out_valid rises SETTLE+1 edges after the final accepted byte; no new bytes are taken until the result is handed off.
module dtree_seq_ctrl #(
    parameter int NUM_FEAT = 45,
    parameter int FEAT_W   = 8,
    parameter int CLASS_W  = 5,
    parameter int SETTLE   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEAT_W-1:0]          in_data,
    input  logic                       in_last,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]         tree_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic                       out_err,
    output logic [15:0]                frame_cnt
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int BUS_W = NUM_FEAT * FEAT_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEAT - 1);
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [BUS_W-1:0]   feat_q, feat_d;
    logic               err_q, err_d;
    logic [CLASS_W-1:0] out_class_q, out_class_d;
    logic               out_err_q, out_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_end;
    logic               at_last_idx;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        feat_d      = feat_q;
        err_d       = err_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;
        frame_cnt_d = frame_cnt_q;
        at_last_idx = (idx_q == LAST_IDX);
        frame_end   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    // An early in_last zeroes every feature above the current slot.
                    for (int i = 0; i < NUM_FEAT; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            feat_d[i*FEAT_W +: FEAT_W] = in_data;
                        end else if (in_last && (IDX_W'(i) > idx_q)) begin
                            feat_d[i*FEAT_W +: FEAT_W] = '0;
                        end
                    end
                    frame_end = in_last || at_last_idx;
                    if (frame_end) begin
                        err_d   = !(in_last && at_last_idx);
                        idx_d   = '0;
                        cnt_d   = SETTLE_LD;
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    out_class_d = tree_class;
                    out_err_d   = err_q;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            feat_q      <= '0;
            err_q       <= 1'b0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            feat_q      <= feat_d;
            err_q       <= err_d;
            out_class_q <= out_class_d;
            out_err_q   <= out_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign feat_bus  = feat_q;
    assign out_class = out_class_q;
    assign out_err   = out_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Randomized bench for dtree_seq_ctrl: a frame-level reference model is compared every cycle, plus literal spot checks.
module tb_dtree_seq_ctrl;

    localparam int N  = 45;
    localparam int FW = 8;
    localparam int CW = 5;
    localparam int ST = 4;
    localparam int BW = N * FW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          in_last;
    logic [BW-1:0] feat_bus;
    logic [CW-1:0] tree_class;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_class;
    logic          out_err;
    logic [15:0]   frame_cnt;

    dtree_seq_ctrl #(.NUM_FEAT(N), .FEAT_W(FW), .CLASS_W(CW), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .feat_bus(feat_bus), .tree_class(tree_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs; out_ready and tree_class are owned by one background process.
    logic          or_val = 1'b1;
    logic          or_rand = 1'b0;
    logic [CW-1:0] tc_val = '0;
    logic          tc_rand = 1'b0;
    logic          chk_en = 1'b0;
    logic [7:0]    fdata [N];

    // Model state, expressed as frame bookkeeping plus an absolute cycle stamp.
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_outv = 0;
    int          m_tacc = 0;
    int          m_idx = 0;
    bit          m_err = 0;
    logic [7:0]  m_feat [N];
    logic [CW-1:0] m_class = '0;
    bit          m_oerr = 0;
    int          m_cnt = 0;
    int          m_handoffs = 0;
    int          preset_seq = 0;
    int          preset_seen = 0;
    int          preset_val = 0;
    logic [BW-1:0] exp_bus;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: expected event did not occur within its bound (t=%0t)", name, $time);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_feat[i] = '0;
    end

    always @(posedge clk) begin : model
        if (preset_seq != preset_seen) begin
            m_cnt = preset_val;
            preset_seen = preset_seq;
        end
        cyc++;
        if (rst) begin
            m_busy = 0; m_outv = 0; m_idx = 0; m_err = 0;
            m_class = '0; m_oerr = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) m_feat[i] = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_feat[m_idx] = in_data;
                if (m_idx == N - 1 || in_last) begin
                    for (int i = m_idx + 1; i < N; i++) m_feat[i] = '0;
                    m_err  = !(m_idx == N - 1 && in_last);
                    m_busy = 1;
                    m_tacc = cyc;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end else if (!m_outv) begin
            if (cyc == m_tacc + ST + 1) begin
                m_class = tree_class;
                m_oerr  = m_err;
                m_outv  = 1;
            end
        end else if (out_ready) begin
            if (m_cnt < 65535) m_cnt++;
            m_busy = 0;
            m_outv = 0;
            m_handoffs++;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (chk_en) begin
            for (int i = 0; i < N; i++) exp_bus[i*FW +: FW] = m_feat[i];
            check("in_ready", 64'(in_ready), 64'(!m_busy));
            check("out_valid", 64'(out_valid), 64'(m_outv));
            check("out_class", 64'(out_class), 64'(m_class));
            check("out_err", 64'(out_err), 64'(m_oerr));
            check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
            check_bus("feat_bus", feat_bus, exp_bus);
        end
    end

    initial begin : side_inputs
        out_ready  = 1'b1;
        tree_class = '0;
        forever begin
            @(posedge clk);
            #2;
            out_ready  = or_rand ? 1'($urandom) : or_val;
            tree_class = tc_rand ? CW'($urandom) : tc_val;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        guard = 0;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input int last_at, input int gapmax);
        for (int i = 0; i < n; i++)
            send_byte(fdata[i], 1'(i == last_at), (gapmax > 0) ? $urandom_range(gapmax, 0) : 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic wait_outv(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        if (!out_valid) fail_now("out_valid_wait");
    endtask

    task automatic wait_handoff();
        int prev;
        int g;
        prev = m_handoffs;
        g = 0;
        while (m_handoffs == prev && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (m_handoffs == prev) fail_now("handoff_wait");
    endtask

    function automatic logic [BW-1:0] fdata_bus(input int upto);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < upto; i++) b[i*FW +: FW] = fdata[i];
        return b;
    endfunction

    initial begin : driver
        int lat;
        logic [BW-1:0] lit;
        int len;
        int last_at;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        rst      = 1'b1;
        tc_val   = 5'd13;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        check("reset_out_class", 64'(out_class), 64'd0);
        check_bus("reset_feat_bus", feat_bus, '0);

        // Nominal frame: bytes i+1, last on byte 44, tree_class 13.
        for (int i = 0; i < N; i++) fdata[i] = 8'(i + 1);
        send_frame(N, N - 1, 0);
        wait_outv(lat);
        check("nominal_latency", 64'(lat), 64'd5);
        check("nominal_class", 64'(out_class), 64'd13);
        check("nominal_err", 64'(out_err), 64'd0);
        for (int i = 0; i < N; i++) lit[i*FW +: FW] = 8'(i + 1);
        check_bus("nominal_feat", feat_bus, lit);
        wait_handoff();
        check("nominal_frame_cnt", 64'(frame_cnt), 64'd1);

        // Early last on byte 9.
        tc_val = 5'd3;
        for (int i = 0; i < N; i++) fdata[i] = 8'($urandom);
        send_frame(10, 9, 0);
        wait_outv(lat);
        check_bus("early_tail_zero", {80'b0, feat_bus[BW-1:80]}, '0);
        check_bus("early_head", {280'b0, feat_bus[79:0]}, fdata_bus(10));
        check("early_class", 64'(out_class), 64'd3);
        check("early_err", 64'(out_err), 64'd1);
        wait_handoff();

        // Missing last, then a well-formed frame.
        for (int i = 0; i < N; i++) fdata[i] = 8'($urandom);
        send_frame(N, -1, 0);
        wait_outv(lat);
        check("missing_last_err", 64'(out_err), 64'd1);
        wait_handoff();
        send_frame(N, N - 1, 0);
        wait_outv(lat);
        check("after_missing_err", 64'(out_err), 64'd0);
        wait_handoff();

        // Backpressure: 20 cycles of out_ready=0 with toggling tree_class and pending input.
        or_val = 1'b0;
        tc_val = 5'd7;
        send_frame(N, N - 1, 0);
        wait_outv(lat);
        tc_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_class", 64'(out_class), 64'd7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        or_val   = 1'b1;
        wait_handoff();
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_frame_cnt", 64'(frame_cnt), 64'd5);
        tc_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_single_handoff", 64'(frame_cnt), 64'd5);

        // Reset mid-SETTLE discards the frame.
        for (int i = 0; i < N; i++) fdata[i] = 8'($urandom);
        send_frame(N, N - 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_out_valid", 64'(out_valid), 64'd0);
        end
        check_bus("rst_feat_zero", feat_bus, '0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        tc_val = 5'd13;
        for (int i = 0; i < N; i++) fdata[i] = 8'(i + 1);
        send_frame(N, N - 1, 0);
        wait_outv(lat);
        check("post_rst_latency", 64'(lat), 64'd5);
        check("post_rst_class", 64'(out_class), 64'd13);
        wait_handoff();
        check("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

        // Same frame with and without input gaps.
        tc_val = 5'd9;
        for (int i = 0; i < N; i++) fdata[i] = 8'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            send_frame(N, N - 1, (pass == 0) ? 0 : 3);
            wait_outv(lat);
            check_bus("gap_feat", feat_bus, fdata_bus(N));
            check("gap_class", 64'(out_class), 64'd9);
            wait_handoff();
        end

        // Random frames with random backpressure and tree_class.
        or_rand = 1'b1;
        tc_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(N, 1);
            last_at = (len == N && ($urandom % 2 == 1)) ? -1 : len - 1;
            for (int i = 0; i < N; i++) fdata[i] = 8'($urandom);
            send_frame(len, last_at, 2);
            wait_handoff();
        end
        or_rand = 1'b0;
        tc_rand = 1'b0;

        // frame_cnt saturation.
        repeat (3) @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFD;
        preset_val = 16'hFFFD;
        preset_seq++;
        @(negedge clk);
        release dut.frame_cnt_q;
        for (int k = 0; k < 4; k++) begin
            send_frame(N, N - 1, 0);
            wait_handoff();
        end
        check("sat_frame_cnt", 64'(frame_cnt), 64'hFFFF);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
